case_restore_stream: RTL

- Inverse of the case converter. Accepts a stream of converted characters, each with its `cap` flag, and restores the original ASCII character.
- Buffers results in a small FIFO behind valid/ready handshakes.
- Flags inconsistent (char, cap) pairs and keeps letter and error statistics.
- Sits on the receive side of the character path, after the link that carries converted text.

---
 rtl/case_restore_stream.sv | 123 ++++++++++++
 1 files changed

// File: rtl/case_restore_stream.sv
// Restores original ASCII characters from (converted char, cap flag) pairs.
// Results queue in a small FIFO; inconsistent pairs are flagged and counted.
module case_restore_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_char,
  input  logic                       in_cap,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_char,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           letter_cnt,
  output logic [CNT_W-1:0]           err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_next;
  logic [LW-1:0] level;
  logic          ready_en;
  logic [8:0]    head_reg;
  logic [8:0]    head_next;
  logic          head_load;

  logic       accept;
  logic       pop;
  logic       is_upper;
  logic       is_lower;
  logic       is_letter;
  logic [7:0] restored;
  logic       err;

  assign in_ready   = ready_en && (level < LW'(DEPTH));
  assign out_valid  = (level != '0);
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign fifo_level = level;
  assign out_char   = head_reg[7:0];
  assign out_err    = head_reg[8];

  always_comb begin
    is_upper  = (in_char >= 8'h41) && (in_char <= 8'h5A);
    is_lower  = (in_char >= 8'h61) && (in_char <= 8'h7A);
    is_letter = is_upper || is_lower;
    restored  = in_char;
    err       = in_cap;
    if (is_upper) begin
      restored = in_cap ? in_char : in_char + 8'h20;
      err      = in_cap;
    end else if (is_lower) begin
      restored = in_cap ? in_char - 8'h20 : in_char;
      err      = !in_cap;
    end
  end

  // The head register must be reloaded whenever the entry it shows changes;
  // a write landing exactly at the new head position is bypassed in.
  always_comb begin
    rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    head_load   = pop ? ((level > LW'(1)) || accept) : (accept && (level == '0));
    if (accept && (wr_ptr == rd_ptr_next)) begin
      head_next = {err, restored};
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {err, restored};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready_en <= 1'b0;
      head_reg <= '0;
    end else begin
      ready_en <= 1'b1;
      rd_ptr   <= rd_ptr_next;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (head_load) begin
        head_reg <= head_next;
      end
      if (accept && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !accept) begin
        level <= level - 1'b1;
      end
    end
  end

  // Statistics saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      letter_cnt <= '0;
      err_cnt    <= '0;
    end else if (accept) begin
      if (is_letter && !err && (letter_cnt != '1)) begin
        letter_cnt <= letter_cnt + 1'b1;
      end
      if (err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
